// File: rtl/prbs31_checker.sv
// PRBS-31 (x^31 + x^28 + 1) receive checker.
// Seeds its LFSR from the incoming stream, verifies a run of clean words, then locks. Once locked
// it counts bit errors against a free-running local LFSR. Word bit order is selected by MSB_FIRST.
module prbs31_checker #(
  parameter int unsigned WIDTH        = 32,
  parameter bit          MSB_FIRST    = 1'b0,
  parameter int unsigned LOCK_WORDS   = 64,
  parameter int unsigned UNLOCK_WORDS = 8,
  parameter int unsigned ERR_WIDTH    = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 din_valid,
  input  logic [WIDTH-1:0]     din,
  input  logic                 clr,
  output logic                 locked,
  output logic                 word_err,
  output logic [WIDTH-1:0]     err_bits,
  output logic [ERR_WIDTH-1:0] err_count,
  output logic [ERR_WIDTH-1:0] word_count
);

  localparam int unsigned RunW = $clog2(LOCK_WORDS + 1);
  localparam int unsigned BadW = $clog2(UNLOCK_WORDS + 1);
  // One spare bit above the counter width (and wide enough for a 128-bit popcount).
  localparam int unsigned SumW = ((ERR_WIDTH > 8) ? ERR_WIDTH : 8) + 1;
  // Fill level recorded after a failed VERIFY reseeds the LFSR from that word.
  localparam logic [7:0] ReloadFill = (WIDTH >= 31) ? 8'd31 : 8'(WIDTH);

  typedef enum logic [1:0] {
    StHunt   = 2'd0,
    StVerify = 2'd1,
    StLocked = 2'd2
  } state_e;

  state_e            state_q;
  logic [30:0]       lfsr_q;
  logic [7:0]        fill_q;
  logic [RunW-1:0]   run_q;
  logic [BadW-1:0]   bad_q;

  logic [30:0]          pred_lfsr;
  logic [30:0]          seed_lfsr;
  logic [WIDTH-1:0]     pred_word;
  logic [WIDTH-1:0]     diff;
  logic [7:0]           pop;
  logic [7:0]           fill_sum;
  logic [ERR_WIDTH-1:0] err_base;
  logic [ERR_WIDTH-1:0] word_base;
  logic [SumW-1:0]      err_sum;
  logic [SumW-1:0]      word_sum;
  logic [ERR_WIDTH-1:0] err_next;
  logic [ERR_WIDTH-1:0] word_next;

  // Position in din of the i-th bit in time.
  function automatic int bit_pos(input int i);
    return MSB_FIRST ? (int'(WIDTH) - 1 - i) : i;
  endfunction

  // Walk the word bit by bit: free-running prediction and a reseed from the received bits.
  always_comb begin
    pred_lfsr = lfsr_q;
    seed_lfsr = lfsr_q;
    pred_word = '0;
    for (int i = 0; i < int'(WIDTH); i++) begin
      pred_word[bit_pos(i)] = pred_lfsr[30] ^ pred_lfsr[27];
      pred_lfsr = {pred_lfsr[29:0], pred_lfsr[30] ^ pred_lfsr[27]};
      seed_lfsr = {seed_lfsr[29:0], din[bit_pos(i)]};
    end
  end

  // Error vector, its popcount and the saturating counter updates.
  always_comb begin
    diff = din ^ pred_word;
    pop  = '0;
    for (int i = 0; i < int'(WIDTH); i++) begin
      pop = pop + {7'd0, diff[i]};
    end
    fill_sum  = fill_q + 8'(WIDTH);
    // A clear coinciding with a locked word restarts the counts from this word.
    err_base  = clr ? '0 : err_count;
    word_base = clr ? '0 : word_count;
    err_sum   = SumW'(err_base) + SumW'(pop);
    word_sum  = SumW'(word_base) + SumW'(1);
    err_next  = (|err_sum[SumW-1:ERR_WIDTH]) ? '1 : err_sum[ERR_WIDTH-1:0];
    word_next = (|word_sum[SumW-1:ERR_WIDTH]) ? '1 : word_sum[ERR_WIDTH-1:0];
  end

  // HUNT/VERIFY/LOCKED state machine with registered outputs; idle cycles hold everything
  // except a management clear of the counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StHunt;
      lfsr_q     <= '0;
      fill_q     <= '0;
      run_q      <= '0;
      bad_q      <= '0;
      locked     <= 1'b0;
      word_err   <= 1'b0;
      err_bits   <= '0;
      err_count  <= '0;
      word_count <= '0;
    end else begin
      if (clr) begin
        err_count  <= '0;
        word_count <= '0;
      end
      if (din_valid) begin
        case (state_q)
          StVerify: begin
            word_err <= 1'b0;
            err_bits <= '0;
            if (|diff) begin
              state_q <= StHunt;
              run_q   <= '0;
              lfsr_q  <= seed_lfsr;
              fill_q  <= ReloadFill;
            end else begin
              lfsr_q <= pred_lfsr;
              if (run_q == RunW'(LOCK_WORDS - 1)) begin
                state_q    <= StLocked;
                locked     <= 1'b1;
                run_q      <= '0;
                bad_q      <= '0;
                err_count  <= '0;
                word_count <= '0;
              end else begin
                run_q <= run_q + 1'b1;
              end
            end
          end
          StLocked: begin
            // Advance on the prediction so a flipped bit is counted exactly once.
            lfsr_q     <= pred_lfsr;
            err_bits   <= diff;
            word_err   <= |diff;
            err_count  <= err_next;
            word_count <= word_next;
            if (|diff) begin
              if (bad_q == BadW'(UNLOCK_WORDS - 1)) begin
                state_q <= StHunt;
                locked  <= 1'b0;
                bad_q   <= '0;
                fill_q  <= '0;
                run_q   <= '0;
              end else begin
                bad_q <= bad_q + 1'b1;
              end
            end else begin
              bad_q <= '0;
            end
          end
          default: begin
            // HUNT (and the unused encoding): shift received bits in as the seed.
            word_err <= 1'b0;
            err_bits <= '0;
            lfsr_q   <= seed_lfsr;
            if (fill_sum >= 8'd31) begin
              state_q <= StVerify;
              fill_q  <= '0;
              run_q   <= '0;
            end else begin
              fill_q <= fill_sum;
            end
          end
        endcase
      end
    end
  end

endmodule
